pattern_generator: RTL
======================

# pattern_generator

Playback counterpart to the capture path: the host loads a pattern into a local dual-port BRAM, then the block streams it sample-by-sample onto a parallel output bus at a programmable rate, with optional external-trigger start and pass repeat. It sits behind the wishbone slave register file in the same single `clk` domain as the bus and drives pins or downstream logic.

## Interface
- `PATTERN_WIDTH`, 32: width of one output sample.
- `PATTERN_DEPTH`, 10: BRAM address bits; capacity = 1 << `PATTERN_DEPTH`.
- `clk` in 1: single clock for bus writes, BRAM and playback.
- `rst` in 1: reset, asynchronous, active-high.
- `i_bram_wr_stb` in 1: write `i_bram_data` to `i_bram_addr[PATTERN_DEPTH-1:0]`.
- `i_bram_addr` in 32: host write address.
- `i_bram_data` in `PATTERN_WIDTH`: host write data.
- `i_start_addr` in 32: first BRAM address played (low `PATTERN_DEPTH` bits used).
- `i_length` in 32: samples per pass; clamped to capacity.
- `i_repeat_count` in 32: extra passes after the first.
- `i_clock_div` in 32: each sample held `i_clock_div + 1` cycles.
- `i_idle_value` in `PATTERN_WIDTH`: output value when not playing.
- `i_ext_trig_en` in 1: when set, wait for `i_ext_trig` before playing.
- `i_ext_trig` in 1: external start, level-sampled.
- `i_force_stb` in 1: start immediately, ignoring the trigger wait.
- `i_enable` in 1: arm/run; low aborts and returns to IDLE.
- `o_pattern_data` out `PATTERN_WIDTH`: registered output sample.
- `o_pattern_stb` out 1: one-cycle pulse when a new sample appears on `o_pattern_data`.
- `o_busy` out 1: high in ARM, PREFETCH, PLAY.
- `o_finished` out 1: high in FINISHED.
- `o_pass_count` out 32: passes completed in the current run.
- `o_capacity` out 32: constant 1 << `PATTERN_DEPTH`.

## Operation
- States: IDLE, ARM, PREFETCH, PLAY, FINISHED.
- IDLE: clear counters; output `i_idle_value`.
  - `i_enable` with `i_length` = 0 goes to FINISHED.
  - `i_enable` with `i_ext_trig_en` goes to ARM.
  - Otherwise `i_enable` goes to PREFETCH.
- ARM: `i_ext_trig` or `i_force_stb` goes to PREFETCH.
- PREFETCH: issue BRAM read at `i_start_addr`.
- PLAY:
  - On each sample boundary, register BRAM dout to `o_pattern_data`, pulse `o_pattern_stb`, and issue the next read address.
  - Read address increments modulo capacity, so a pattern wraps past the top of the BRAM.
  - After `i_length` samples, a pass ends and `o_pass_count` increments.
  - If `o_pass_count` < `i_repeat_count`, the address reloads `i_start_addr` and playback continues seamlessly, with no gap cycle.
  - Otherwise, once the last sample's hold time expires, go to FINISHED.
- FINISHED: output `i_idle_value`; `i_enable` low goes to IDLE.
- `i_enable` low in ARM, PREFETCH or PLAY:
  - Next state is IDLE.
  - `o_pattern_data` shows `i_idle_value` the following cycle.
  - No further strobes.
- `i_force_stb` in IDLE with `i_enable` high is treated as an immediate start.
- Host writes are accepted in every state.
- A write to the address being read in the same cycle returns the old content.
- Configuration inputs are sampled on leaving IDLE and held internally for the run.

## Timing
- Reset values:
  - `o_pattern_data` = 0 (the first IDLE cycle then drives `i_idle_value`).
  - `o_pattern_stb`, `o_busy`, `o_finished` = 0.
  - `o_pass_count` = 0; state = IDLE.
- Latency: `i_enable` sampled high at edge N (no trigger wait) gives first `o_pattern_stb` and data valid after edge N+3.
- With trigger wait: trigger sampled at edge T gives first sample after edge T+3.
- Sample spacing: exactly `i_clock_div + 1` cycles between strobes, including across pass boundaries.
- `i_clock_div` all-ones is legal: the hold counter is 32 bits and must not overflow to 0.
- `o_finished` rises on the cycle after the final hold period ends.

## Structure
- Shared package holds:
  - State encodings.
  - Default width and depth constants.
  - Capacity expression.
- Sub-module `dpb`:
  - Port A: host write.
  - Port B: playback read, read-only.
  - Both ports on `clk`.

## Test plan
- Load 0..7; length 8, div 0, repeat 0 → strobes on 8 consecutive cycles with data 0..7, then `i_idle_value`, `o_finished` = 1.
- Start 1022, length 4, depth 10 → data sequence from addresses 1022, 1023, 0, 1.
- Length 3, repeat 2, div 2 → 9 strobes exactly 3 cycles apart with no gap at pass boundaries; `o_pass_count` = 3 at finish.
- `i_ext_trig_en` = 1 → stays in ARM with no strobe for 100 cycles; `i_ext_trig` pulse → first strobe 3 edges later.
- Drop `i_enable` mid-PLAY, then separately assert `rst` mid-PLAY → output `i_idle_value` / 0 respectively, strobes stop, `o_busy` = 0.
- Length 0 → immediate FINISHED with zero strobes.

Source files
------------

// File: rtl/pattern_generator_pkg.sv
// Shared types and constants for the pattern playback block.
package pattern_generator_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_PREFETCH,
    ST_PLAY,
    ST_FINISHED
  } state_t;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 10;

  function automatic logic [31:0] capacity_of(input int depth);
    return 32'd1 << depth;
  endfunction

endpackage

// File: rtl/pattern_generator_dpb.sv
// Dual-port pattern RAM: port A host write, port B playback read, single clock.
module pattern_generator_dpb
  import pattern_generator_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [DEPTH-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [DEPTH-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [0:(1<<DEPTH)-1];

  // NOTE: no reset on the array so it maps onto block RAM; a same-address
  // write and read in one cycle returns the old word because both use <=.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/pattern_generator.sv
// Streams a BRAM-resident pattern onto a parallel bus at a programmable rate,
// with optional external-trigger start and pass repeat.
module pattern_generator
  import pattern_generator_pkg::*;
#(
  parameter int PATTERN_WIDTH = DEFAULT_WIDTH,
  parameter int PATTERN_DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_bram_wr_stb,
  input  logic [31:0]              i_bram_addr,
  input  logic [PATTERN_WIDTH-1:0] i_bram_data,
  input  logic [31:0]              i_start_addr,
  input  logic [31:0]              i_length,
  input  logic [31:0]              i_repeat_count,
  input  logic [31:0]              i_clock_div,
  input  logic [PATTERN_WIDTH-1:0] i_idle_value,
  input  logic                     i_ext_trig_en,
  input  logic                     i_ext_trig,
  input  logic                     i_force_stb,
  input  logic                     i_enable,
  output logic [PATTERN_WIDTH-1:0] o_pattern_data,
  output logic                     o_pattern_stb,
  output logic                     o_busy,
  output logic                     o_finished,
  output logic [31:0]              o_pass_count,
  output logic [31:0]              o_capacity
);

  localparam logic [31:0] CAPACITY = capacity_of(PATTERN_DEPTH);

  state_t                     state, state_next;
  logic [PATTERN_DEPTH-1:0]   cfg_start, rd_addr;
  logic [31:0]                cfg_len, cfg_repeat, cfg_div, len_clamped;
  logic [31:0]                rd_idx, smp_cnt, hold_cnt, pass_count;
  logic                       fill, done, boundary, strobe_now, rd_issue;
  logic [PATTERN_WIDTH-1:0]   rd_data;
  logic                       unused_upper_bits;

  assign unused_upper_bits = ^{i_bram_addr[31:PATTERN_DEPTH], i_start_addr[31:PATTERN_DEPTH]};

  pattern_generator_dpb #(.WIDTH(PATTERN_WIDTH), .DEPTH(PATTERN_DEPTH)) u_dpb (
    .clk     (clk),
    .wr_en   (i_bram_wr_stb),
    .wr_addr (i_bram_addr[PATTERN_DEPTH-1:0]),
    .wr_data (i_bram_data),
    .rd_en   (rd_issue),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign len_clamped = (i_length > CAPACITY) ? CAPACITY : i_length;
  // The cycle after PREFETCH fills rd_data with the first sample; after that
  // rd_data always holds the sample due at the next boundary.
  assign boundary    = (state == ST_PLAY) && !fill && (hold_cnt == 32'd0);
  assign strobe_now  = boundary && !done && i_enable;
  assign rd_issue    = (state == ST_PLAY) && (fill || (boundary && !done));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // NOTE: default assignment first so every path drives state_next (no latch).
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:
        if (i_enable) begin
          if (i_length == 32'd0)                 state_next = ST_FINISHED;
          else if (i_ext_trig_en && !i_force_stb) state_next = ST_ARM;
          else                                    state_next = ST_PREFETCH;
        end
      ST_ARM:
        if (!i_enable)                      state_next = ST_IDLE;
        else if (i_ext_trig || i_force_stb) state_next = ST_PREFETCH;
      ST_PREFETCH:
        state_next = i_enable ? ST_PLAY : ST_IDLE;
      ST_PLAY:
        if (!i_enable)            state_next = ST_IDLE;
        else if (boundary && done) state_next = ST_FINISHED;
      ST_FINISHED:
        if (!i_enable) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy     = (state == ST_ARM) || (state == ST_PREFETCH) || (state == ST_PLAY);
    o_finished = (state == ST_FINISHED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_start      <= '0;
      cfg_len        <= '0;
      cfg_repeat     <= '0;
      cfg_div        <= '0;
      rd_addr        <= '0;
      rd_idx         <= '0;
      smp_cnt        <= '0;
      hold_cnt       <= '0;
      pass_count     <= '0;
      fill           <= 1'b0;
      done           <= 1'b0;
      o_pattern_stb  <= 1'b0;
      o_pattern_data <= '0;
    end else begin
      o_pattern_stb <= strobe_now;
      if (strobe_now)               o_pattern_data <= rd_data;
      else if (state_next != ST_PLAY) o_pattern_data <= i_idle_value;

      case (state)
        ST_IDLE: begin
          rd_idx     <= '0;
          smp_cnt    <= '0;
          hold_cnt   <= '0;
          pass_count <= '0;
          fill       <= 1'b0;
          done       <= 1'b0;
          if (i_enable) begin
            cfg_start  <= i_start_addr[PATTERN_DEPTH-1:0];
            cfg_len    <= len_clamped;
            cfg_repeat <= i_repeat_count;
            cfg_div    <= i_clock_div;
          end
        end
        ST_PREFETCH: begin
          rd_addr <= cfg_start;
          rd_idx  <= '0;
          fill    <= 1'b1;
        end
        ST_PLAY: begin
          fill <= 1'b0;
          // Read side reloads the start address itself so passes join seamlessly.
          if (rd_issue) begin
            if (rd_idx == cfg_len - 32'd1) begin
              rd_addr <= cfg_start;
              rd_idx  <= '0;
            end else begin
              rd_addr <= rd_addr + 1'b1;
              rd_idx  <= rd_idx + 32'd1;
            end
          end
          if (boundary && !done) begin
            hold_cnt <= cfg_div;
            if (smp_cnt == cfg_len - 32'd1) begin
              smp_cnt    <= '0;
              pass_count <= pass_count + 32'd1;
              if (pass_count >= cfg_repeat) done <= 1'b1;
            end else begin
              smp_cnt <= smp_cnt + 32'd1;
            end
          end else if (hold_cnt != 32'd0) begin
            hold_cnt <= hold_cnt - 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_pass_count = pass_count;
  assign o_capacity   = CAPACITY;

endmodule
